// File: rtl/dkong3_obj_pkg.sv
// Shared types and constants for the object RAM / line scanner block.
package dkong3_obj_pkg;

    localparam int NUM_OBJ      = 96;
    localparam int MAX_PER_LINE = 16;
    localparam int OBJ_HEIGHT   = 16;
    localparam int FIFO_DEPTH   = 16;

    localparam int IDX_W = $clog2(NUM_OBJ);
    localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
    localparam int ROW_W = $clog2(OBJ_HEIGHT);

    // Byte offsets inside one 4-byte object entry
    localparam logic [1:0] OFS_Y    = 2'd0;
    localparam logic [1:0] OFS_CODE = 2'd1;
    localparam logic [1:0] OFS_ATTR = 2'd2;
    localparam logic [1:0] OFS_X    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_Y = 3'd1,
        ST_CHK  = 3'd2,
        ST_RD_C = 3'd3,
        ST_RD_A = 3'd4,
        ST_RD_X = 3'd5,
        ST_PUSH = 3'd6
    } scan_state_e;

    typedef struct packed {
        logic [7:0]       code;
        logic [7:0]       attr;
        logic [7:0]       x;
        logic [ROW_W-1:0] row;
    } hit_rec_t;

    // RAM byte address of field `ofs` of object `n`
    function automatic logic [9:0] obj_addr(input logic [IDX_W-1:0] n, input logic [1:0] ofs);
        return 10'({n, ofs});
    endfunction

endpackage

// File: rtl/dkong3_obj_fifo.sv
// Hit FIFO between the line scanner and the sprite renderer.
// Flush has priority over push and pop and empties the FIFO at the next edge.
module dkong3_obj_fifo
    import dkong3_obj_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
)
(
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     push,
    input  hit_rec_t push_data,
    input  logic     pop,
    output hit_rec_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W_F = PTR_W + 1;
    localparam logic [CNT_W_F-1:0] DEPTH_CNT = CNT_W_F'(DEPTH);

    hit_rec_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W_F-1:0] count_q, count_d;
    logic               do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);
    assign head  = mem_q[rd_ptr_q];

    // Pointer / occupancy update; simultaneous push and pop leaves the count unchanged
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, no reset needed: the head is qualified by !empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dkong3_obj_scan.sv
// Object RAM ($7000 block) shared by sprite DMA, the main CPU and a per-line
// object scanner that queues the objects touching the upcoming line.
//
// Renderer handshake: a hit record transfers on every rising edge where
// O_OBJ_VALID and I_OBJ_READY are both high; while VALID is high and READY low
// the head fields are held stable; VALID never drops without a transfer except
// on a flush (line start) or reset.
module dkong3_obj_scan
    import dkong3_obj_pkg::*;
(
    input  logic       I_CLK_12M,
    input  logic       I_RESET,
    input  logic [9:0] I_DMAD_A,
    input  logic [7:0] I_DMAD_D,
    input  logic       I_DMAD_CE,
    input  logic [9:0] I_CPU_A,
    input  logic [7:0] I_CPU_D,
    input  logic       I_OBJ_RQn,
    input  logic       I_OBJ_WRn,
    input  logic       I_OBJ_RDn,
    output logic [7:0] O_CPU_D,
    input  logic       I_LINE_START,
    input  logic [7:0] I_VPOS,
    output logic       O_OBJ_VALID,
    input  logic       I_OBJ_READY,
    output logic [7:0] O_OBJ_CODE,
    output logic [7:0] O_OBJ_ATTR,
    output logic [7:0] O_OBJ_X,
    output logic [3:0] O_OBJ_ROW,
    output logic       O_SCAN_BUSY,
    output logic       O_OVERFLOW
);

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       vpos_q, vpos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    hit_rec_t         rec_q, rec_d, rec_cur;
    logic             scan_rd_q, scan_rd_d;
    logic [1:0]       scan_ofs_q, scan_ofs_d;
    logic             cpu_rd_q, cpu_rd_d;

    logic [7:0]       ram_mem [1024];
    logic [7:0]       ram_rdata_q;
    logic [9:0]       ram_addr;
    logic [7:0]       ram_wdata;
    logic             ram_we;

    logic             scan_req, scan_grant;
    logic [1:0]       scan_ofs;
    logic             cpu_acc;
    logic [7:0]       obj_y, obj_dy;
    logic             obj_hit, last_obj;
    logic             fifo_push, fifo_flush, fifo_full, fifo_empty;
    hit_rec_t         fifo_head;

    // Scanner read request: which byte of the current object each read state wants
    always_comb begin
        scan_req = 1'b0;
        scan_ofs = OFS_Y;
        case (state_q)
            ST_RD_Y: begin scan_req = 1'b1; scan_ofs = OFS_Y;    end
            ST_RD_C: begin scan_req = 1'b1; scan_ofs = OFS_CODE; end
            ST_RD_A: begin scan_req = 1'b1; scan_ofs = OFS_ATTR; end
            ST_RD_X: begin scan_req = 1'b1; scan_ofs = OFS_X;    end
            default: ;
        endcase
        if (I_LINE_START) begin
            scan_req = 1'b0;
        end
    end

    // Single RAM port arbitration: DMA, then CPU, then scanner
    always_comb begin
        cpu_acc    = !I_OBJ_RQn && (!I_OBJ_WRn || !I_OBJ_RDn);
        ram_addr   = obj_addr(idx_q, scan_ofs);
        ram_wdata  = I_DMAD_D;
        ram_we     = 1'b0;
        scan_grant = 1'b0;
        cpu_rd_d   = 1'b0;
        if (I_DMAD_CE) begin
            ram_addr = I_DMAD_A;
            ram_we   = 1'b1;
        end else if (cpu_acc) begin
            ram_addr  = I_CPU_A;
            ram_wdata = I_CPU_D;
            ram_we    = !I_OBJ_WRn;
            cpu_rd_d  = !I_OBJ_RDn;
        end else begin
            scan_grant = scan_req;
        end
        // Nothing may land in RAM during a reset cycle
        if (I_RESET) begin
            ram_we = 1'b0;
        end
        scan_rd_d  = scan_grant;
        scan_ofs_d = scan_ofs;
    end

    // Object RAM with one-cycle registered read
    always_ff @(posedge I_CLK_12M) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
        ram_rdata_q <= ram_mem[ram_addr];
    end

    // Fold the byte returned by last cycle's scanner read into the hit record; evaluate Y
    always_comb begin
        rec_cur = rec_q;
        if (scan_rd_q) begin
            case (scan_ofs_q)
                OFS_CODE: rec_cur.code = ram_rdata_q;
                OFS_ATTR: rec_cur.attr = ram_rdata_q;
                OFS_X:    rec_cur.x    = ram_rdata_q;
                default:  ;
            endcase
        end
        obj_y    = ram_rdata_q;
        obj_dy   = vpos_q - obj_y;
        obj_hit  = (obj_y != 8'h00) && (obj_dy < 8'(OBJ_HEIGHT));
        last_obj = (idx_q == IDX_W'(NUM_OBJ - 1));
    end

    // Scan FSM next state; a line start from any state restarts at object 0
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vpos_d     = vpos_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        rec_d      = rec_cur;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        if (I_LINE_START) begin
            state_d    = ST_RD_Y;
            idx_d      = '0;
            vpos_d     = I_VPOS;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            fifo_flush = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_RD_Y: if (scan_grant) state_d = ST_CHK;
                ST_CHK: begin
                    if (obj_hit) begin
                        if (cnt_q == CNT_W'(MAX_PER_LINE)) begin
                            ovf_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            rec_d.row = obj_dy[ROW_W-1:0];
                            state_d   = ST_RD_C;
                        end
                    end else if (last_obj) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RD_Y;
                    end
                end
                ST_RD_C: if (scan_grant) state_d = ST_RD_A;
                ST_RD_A: if (scan_grant) state_d = ST_RD_X;
                ST_RD_X: if (scan_grant) state_d = ST_PUSH;
                ST_PUSH: begin
                    fifo_push = 1'b1;
                    if (!fifo_full) begin
                        cnt_d = cnt_q + 1'b1;
                        if (last_obj) begin
                            state_d = ST_IDLE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_RD_Y;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Scanner and CPU read-tracking registers
    always_ff @(posedge I_CLK_12M) begin
        if (I_RESET) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            vpos_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rec_q      <= '0;
            scan_rd_q  <= 1'b0;
            scan_ofs_q <= OFS_Y;
            cpu_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            vpos_q     <= vpos_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rec_q      <= rec_d;
            scan_rd_q  <= scan_rd_d;
            scan_ofs_q <= scan_ofs_d;
            cpu_rd_q   <= cpu_rd_d;
        end
    end

    dkong3_obj_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (I_CLK_12M),
        .rst       (I_RESET),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (rec_cur),
        .pop       (I_OBJ_READY),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign O_OBJ_VALID = !fifo_empty;
    assign O_OBJ_CODE  = fifo_empty ? 8'h00 : fifo_head.code;
    assign O_OBJ_ATTR  = fifo_empty ? 8'h00 : fifo_head.attr;
    assign O_OBJ_X     = fifo_empty ? 8'h00 : fifo_head.x;
    assign O_OBJ_ROW   = fifo_empty ? 4'h0  : fifo_head.row;
    assign O_SCAN_BUSY = (state_q != ST_IDLE);
    assign O_OVERFLOW  = ovf_q;
    assign O_CPU_D     = cpu_rd_q ? ram_rdata_q : 8'h00;

endmodule

// File: tb/tb_dkong3_obj_scan.sv
// Bench for dkong3_obj_scan: object list scan against a list-walking model.
module tb_dkong3_obj_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] dmad_a;
    logic [7:0] dmad_d;
    logic       dmad_ce;
    logic [9:0] cpu_a;
    logic [7:0] cpu_di;
    logic       obj_rqn, obj_wrn, obj_rdn;
    logic [7:0] cpu_do;
    logic       line_start;
    logic [7:0] vpos;
    logic       obj_valid, obj_ready;
    logic [7:0] obj_code, obj_attr, obj_x;
    logic [3:0] obj_row;
    logic       scan_busy, overflow;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] ram_model [1024];
    logic [27:0] exp_q[$];
    logic [27:0] got_q[$];
    logic       exp_ovf;
    bit         timed_out;

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    dkong3_obj_scan dut (
        .I_CLK_12M    (clk),
        .I_RESET      (rst),
        .I_DMAD_A     (dmad_a),
        .I_DMAD_D     (dmad_d),
        .I_DMAD_CE    (dmad_ce),
        .I_CPU_A      (cpu_a),
        .I_CPU_D      (cpu_di),
        .I_OBJ_RQn    (obj_rqn),
        .I_OBJ_WRn    (obj_wrn),
        .I_OBJ_RDn    (obj_rdn),
        .O_CPU_D      (cpu_do),
        .I_LINE_START (line_start),
        .I_VPOS       (vpos),
        .O_OBJ_VALID  (obj_valid),
        .I_OBJ_READY  (obj_ready),
        .O_OBJ_CODE   (obj_code),
        .O_OBJ_ATTR   (obj_attr),
        .O_OBJ_X      (obj_x),
        .O_OBJ_ROW    (obj_row),
        .O_SCAN_BUSY  (scan_busy),
        .O_OVERFLOW   (overflow)
    );

    // Reference model: walk the object list for one line
    task automatic model_scan(input logic [7:0] v);
        int cnt;
        logic [7:0] y, d;
        cnt = 0;
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int n = 0; n < 96; n++) begin
            y = ram_model[4*n];
            d = v - y;
            if (y != 8'h00 && d < 8'd16) begin
                if (cnt == 16) begin
                    exp_ovf = 1'b1;
                    break;
                end
                exp_q.push_back({ram_model[4*n+1], ram_model[4*n+2], ram_model[4*n+3], d[3:0]});
                cnt++;
            end
        end
    endtask

    // Driver tasks
    task automatic dma_wr(input logic [9:0] a, input logic [7:0] d);
        dmad_ce = 1'b1;
        dmad_a  = a;
        dmad_d  = d;
        ram_model[a] = d;
        @(posedge clk); #1;
    endtask

    task automatic dma_obj(input int n, input logic [7:0] y, input logic [7:0] c,
                           input logic [7:0] a, input logic [7:0] x);
        dma_wr(10'(4*n),     y);
        dma_wr(10'(4*n + 1), c);
        dma_wr(10'(4*n + 2), a);
        dma_wr(10'(4*n + 3), x);
        dmad_ce = 1'b0;
    endtask

    task automatic pulse_line(input logic [7:0] v);
        obj_ready  = 1'b0;
        vpos       = v;
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    task automatic cpu_read(input logic [9:0] a);
        obj_rqn = 1'b0;
        obj_rdn = 1'b0;
        cpu_a   = a;
        @(posedge clk); #1;
        obj_rqn = 1'b1;
        obj_rdn = 1'b1;
    endtask

    // Accept records with random READY until scan done and FIFO empty
    task automatic collect(input int max_cycles, input int ready_pct);
        got_q.delete();
        timed_out = 1'b0;
        for (int i = 0; i <= max_cycles; i++) begin
            if (i == max_cycles) begin
                timed_out = 1'b1;
                break;
            end
            if (i > 0 && !obj_valid && !scan_busy) break;
            obj_ready = ($urandom_range(99) < ready_pct);
            if (obj_valid && obj_ready)
                got_q.push_back({obj_code, obj_attr, obj_x, obj_row});
            @(posedge clk); #1;
        end
        obj_ready = 1'b0;
    endtask

    task automatic fill_ram();
        for (int a = 0; a < 1024; a++)
            dma_wr(10'(a), (a % 4 == 0) ? 8'h00 : 8'($urandom));
        dmad_ce = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++; if (obj_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", obj_valid); end
        n_checks++; if (scan_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", scan_busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        n_checks++; if (cpu_do !== 8'h00) begin n_fail++; $display("FAIL rst_cpu_d got=%h exp=00", cpu_do); end
        n_checks++; if ({obj_code, obj_attr, obj_x, obj_row} !== 28'h0) begin
            n_fail++; $display("FAIL rst_head got=%h exp=0", {obj_code, obj_attr, obj_x, obj_row});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (scan_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle got=%b exp=0", scan_busy); end
    endtask

    task automatic test_single_hit();
        dma_obj(0, 8'h40, 8'h12, 8'h05, 8'h80);
        pulse_line(8'h45);
        model_scan(8'h45);
        n_checks++; if (scan_busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_start got=%b exp=1", scan_busy); end
        collect(2000, 100);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL t1_timeout got=busy exp=idle"); end
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL t1_count got=%0d exp=1", got_q.size()); end
        n_checks++; if (got_q.size() > 0 && got_q[0] !== {8'h12, 8'h05, 8'h80, 4'h5}) begin
            n_fail++; $display("FAIL t1_entry got=%h exp=%h", got_q[0], {8'h12, 8'h05, 8'h80, 4'h5});
        end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t1_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_wrap_disable();
        dma_obj(1, 8'hF8, 8'h34, 8'h56, 8'h78);
        dma_obj(2, 8'h00, 8'h9A, 8'hBC, 8'hDE);
        pulse_line(8'h02);
        collect(2000, 70);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL t2_timeout got=busy exp=idle"); end
        n_checks++; if (got_q.size() != 1 || got_q[0] !== {8'h34, 8'h56, 8'h78, 4'hA}) begin
            n_fail++; $display("FAIL t2_wrap got=%0d entries first=%h exp=1 entry %h", got_q.size(),
                               (got_q.size() > 0) ? got_q[0] : 28'h0, {8'h34, 8'h56, 8'h78, 4'hA});
        end
        pulse_line(8'h50);
        collect(2000, 70);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL t2_d16_miss got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_overflow();
        for (int n = 0; n < 20; n++)
            dma_obj(n, 8'h10, 8'($urandom), 8'($urandom), 8'($urandom));
        pulse_line(8'h10);
        model_scan(8'h10);
        collect(3000, 50);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL t3_timeout got=busy exp=idle"); end
        n_checks++; if (got_q.size() != 16) begin n_fail++; $display("FAIL t3_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t3_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL t3_ovf_set got=%b exp=1", overflow); end
        pulse_line(8'h80);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t3_ovf_clear got=%b exp=0", overflow); end
        collect(2000, 100);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL t3_miss_line got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_backpressure();
        int cyc;
        pulse_line(8'h10);
        model_scan(8'h10);
        cyc = 0;
        while (scan_busy && cyc < 600) begin
            if (obj_valid) begin
                n_checks++; if ({obj_code, obj_attr, obj_x, obj_row} !== exp_q[0]) begin
                    n_fail++; $display("FAIL t4_head_hold got=%h exp=%h", {obj_code, obj_attr, obj_x, obj_row}, exp_q[0]);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (scan_busy !== 1'b0) begin n_fail++; $display("FAIL t4_busy_timeout got=1 exp=0"); end
        n_checks++; if (obj_valid !== 1'b1) begin n_fail++; $display("FAIL t4_valid got=%b exp=1", obj_valid); end
        n_checks++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL t4_ovf got=%b exp=%b", overflow, exp_ovf); end
        collect(200, 100);
        n_checks++; if (got_q.size() != 16) begin n_fail++; $display("FAIL t4_drain_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t4_order%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_collision();
        logic [7:0] d1;
        dma_obj(0, 8'h40, 8'h21, 8'h43, 8'h65);
        pulse_line(8'h45);
        model_scan(8'h45);
        for (int i = 0; i < 6; i++) begin
            d1 = 8'($urandom);
            dmad_ce = 1'b1; dmad_a = 10'h3E0 + 10'(i); dmad_d = d1;
            ram_model[10'h3E0 + 10'(i)] = d1;
            obj_rqn = 1'b0; obj_wrn = 1'b0; cpu_a = 10'h3E0 + 10'(i); cpu_di = ~d1;
            @(posedge clk); #1;
        end
        dmad_ce = 1'b0;
        cpu_a = 10'h3E8; cpu_di = 8'hC3; ram_model[10'h3E8] = 8'hC3;
        @(posedge clk); #1;
        obj_rqn = 1'b1; obj_wrn = 1'b1;
        n_checks++; if (obj_valid !== 1'b0 || scan_busy !== 1'b1) begin
            n_fail++; $display("FAIL t5_scan_held got=valid %b busy %b exp=valid 0 busy 1", obj_valid, scan_busy);
        end
        collect(2000, 80);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL t5_timeout got=busy exp=idle"); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t5_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t5_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        cpu_read(10'h3E0);
        n_checks++; if (cpu_do !== ram_model[10'h3E0]) begin n_fail++; $display("FAIL t5_dma_wins0 got=%h exp=%h", cpu_do, ram_model[10'h3E0]); end
        cpu_read(10'h3E5);
        n_checks++; if (cpu_do !== ram_model[10'h3E5]) begin n_fail++; $display("FAIL t5_dma_wins5 got=%h exp=%h", cpu_do, ram_model[10'h3E5]); end
        cpu_read(10'h3E8);
        n_checks++; if (cpu_do !== 8'hC3) begin n_fail++; $display("FAIL t5_cpu_write got=%h exp=c3", cpu_do); end
        cpu_read(10'h003);
        n_checks++; if (cpu_do !== 8'h65) begin n_fail++; $display("FAIL t5_read_x got=%h exp=65", cpu_do); end
        @(posedge clk); #1;
        n_checks++; if (cpu_do !== 8'h00) begin n_fail++; $display("FAIL t5_or_bus got=%h exp=00", cpu_do); end
    endtask

    task automatic test_abort_reset();
        logic [7:0] keep;
        dma_obj(30, 8'h33, 8'($urandom), 8'($urandom), 8'($urandom));
        dma_obj(40, 8'h30, 8'($urandom), 8'($urandom), 8'($urandom));
        pulse_line(8'h10);
        repeat (30) @(posedge clk);
        #1;
        n_checks++; if (obj_valid !== 1'b1 || scan_busy !== 1'b1) begin
            n_fail++; $display("FAIL t6_mid_scan got=valid %b busy %b exp=valid 1 busy 1", obj_valid, scan_busy);
        end
        pulse_line(8'h35);
        model_scan(8'h35);
        n_checks++; if (obj_valid !== 1'b0) begin n_fail++; $display("FAIL t6_flush got=%b exp=0", obj_valid); end
        collect(2000, 60);
        n_checks++; if (got_q.size() != exp_q.size() || got_q.size() != 2) begin
            n_fail++; $display("FAIL t6_rescan_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t6_rescan%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        pulse_line(8'h10);
        repeat (20) @(posedge clk);
        #1;
        keep = ram_model[10'h3FF];
        rst = 1'b1;
        dmad_ce = 1'b1; dmad_a = 10'h3FF; dmad_d = ~keep;
        @(posedge clk); #1;
        rst = 1'b0;
        dmad_ce = 1'b0;
        n_checks++; if (obj_valid !== 1'b0 || scan_busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL t6_reset_flags got=%b%b%b exp=000", obj_valid, scan_busy, overflow);
        end
        n_checks++; if ({obj_code, obj_attr, obj_x, obj_row, cpu_do} !== 36'h0) begin
            n_fail++; $display("FAIL t6_reset_data got=%h exp=0", {obj_code, obj_attr, obj_x, obj_row, cpu_do});
        end
        cpu_read(10'h3FF);
        n_checks++; if (cpu_do !== keep) begin n_fail++; $display("FAIL t6_reset_dma_ignored got=%h exp=%h", cpu_do, keep); end
    endtask

    task automatic test_random();
        logic [7:0] v, y;
        int near_pct;
        for (int it = 0; it < 5; it++) begin
            v = 8'($urandom);
            near_pct = $urandom_range(5, 40);
            for (int n = 0; n < 96; n++) begin
                if ($urandom_range(99) < near_pct) y = v - 8'($urandom_range(0, 17));
                else if ($urandom_range(9) == 0) y = 8'h00;
                else y = 8'($urandom);
                dma_wr(10'(4*n), y);
                if ($urandom_range(3) == 0) dma_wr(10'(4*n + 3), 8'($urandom));
            end
            dmad_ce = 1'b0;
            pulse_line(v);
            model_scan(v);
            collect(3000, 60);
            n_checks++; if (timed_out) begin n_fail++; $display("FAIL rnd%0d_timeout got=busy exp=idle", it); end
            n_checks++; if (got_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_entry%0d got=%h exp=%h", it, i, got_q[i], exp_q[i]); end
            end
            n_checks++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL rnd%0d_ovf got=%b exp=%b", it, overflow, exp_ovf); end
        end
    endtask

    initial begin
        rst = 1'b1;
        dmad_a = '0; dmad_d = '0; dmad_ce = 1'b0;
        cpu_a = '0; cpu_di = '0;
        obj_rqn = 1'b1; obj_wrn = 1'b1; obj_rdn = 1'b1;
        line_start = 1'b0; vpos = '0; obj_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        fill_ram();
        test_single_hit();
        test_wrap_disable();
        test_overflow();
        test_backpressure();
        test_collision();
        test_abort_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
